// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, legal-op limit and arbiter FSM encoding (LOCK states only with ALU_ARB_LOCK_EN)
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_OR   = 4'd8
  } alu_sel_e;
  localparam logic [3:0] LAST_LEGAL_OP = 4'd8;
  typedef enum logic [1:0] {
    PRI0,
    PRI1
`ifdef ALU_ARB_LOCK_EN
    ,
    LOCK0,
    LOCK1
`endif
  } arb_state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus result channel; master = requesters/consumer, slave = arbiter; lock lines only with ALU_ARB_LOCK_EN
interface alu_arbiter_if #(parameter int DWIDTH = 32);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [3:0]        req0_sel, req1_sel;
  logic [DWIDTH-1:0] req0_a, req1_a, req0_b, req1_b;
`ifdef ALU_ARB_LOCK_EN
  logic              req0_lock, req1_lock;
`endif
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DWIDTH-1:0] rsp_data;
  modport master (
    output req0_valid, req1_valid, req0_sel, req1_sel, req0_a, req1_a, req0_b, req1_b, rsp_ready,
`ifdef ALU_ARB_LOCK_EN
    output req0_lock, req1_lock,
`endif
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input  req0_valid, req1_valid, req0_sel, req1_sel, req0_a, req1_a, req0_b, req1_b, rsp_ready,
`ifdef ALU_ARB_LOCK_EN
    input  req0_lock, req1_lock,
`endif
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu.sv
// alu: combinational ALU; ports sel_i (op code), a_i/b_i (operands), y_o (result, 0 for unknown op)
module alu
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [3:0]        sel_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  output logic [DWIDTH-1:0] y_o
);
  always_comb begin
    y_o = '0;
    case (sel_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_AND:  y_o = a_i & b_i;
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << b_i;
      ALU_SLT:  y_o = {{(DWIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {{(DWIDTH-1){1'b0}}, a_i < b_i};
      ALU_SRL:  y_o = a_i >> b_i;
      ALU_OR:   y_o = a_i | b_i;
      default:  y_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one alu between two requesters with a 1-deep result register; ports clk, rst_n, bus (slave); lock option ALU_ARB_LOCK_EN
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  arb_state_e        state_q;
  logic              rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [DWIDTH-1:0] rsp_data_q;
  logic              free, gnt0, gnt1, acc0, acc1, illegal;
  logic [3:0]        sel_d;
  logic [DWIDTH-1:0] a_d, b_raw, b_d, y;
  always_comb begin
    free = !rsp_valid_q || bus.rsp_ready;
`ifdef ALU_ARB_LOCK_EN
    gnt0 = state_q == LOCK1 ? 1'b0 :
           state_q == LOCK0 ? bus.req0_valid :
           bus.req0_valid && (state_q == PRI0 || !bus.req1_valid);
    gnt1 = state_q != LOCK0 && bus.req1_valid && !gnt0;
`else
    gnt0 = bus.req0_valid && (state_q == PRI0 || !bus.req1_valid);
    gnt1 = bus.req1_valid && !gnt0;
`endif
    // readiness is held low through reset so nothing is accepted while rst_n=0
    acc0 = rst_n && free && gnt0;
    acc1 = rst_n && free && gnt1;
    sel_d = acc1 ? bus.req1_sel : bus.req0_sel;
    a_d = acc1 ? bus.req1_a : bus.req0_a;
    b_raw = acc1 ? bus.req1_b : bus.req0_b;
    // shift amounts use only the low five bits of b
    b_d = (sel_d == ALU_SLL || sel_d == ALU_SRL) ? {{(DWIDTH-5){1'b0}}, b_raw[4:0]} : b_raw;
    illegal = sel_d > LAST_LEGAL_OP;
  end
  alu #(.DWIDTH(DWIDTH)) u_alu (
    .sel_i(sel_d),
    .a_i  (a_d),
    .b_i  (b_d),
    .y_o  (y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRI0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
`ifdef ALU_ARB_LOCK_EN
      if (acc0) state_q <= bus.req0_lock ? LOCK0 : PRI1;
      else if (acc1) state_q <= bus.req1_lock ? LOCK1 : PRI0;
`else
      if (acc0) state_q <= PRI1;
      else if (acc1) state_q <= PRI0;
`endif
      if (acc0 || acc1) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= acc1;
        rsp_err_q   <= illegal;
        rsp_data_q  <= illegal ? '0 : y;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter (lock scenario only with ALU_ARB_LOCK_EN)
module tb_alu_arbiter;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [34:0] rsp;
  logic [1:0] rdy;
  alu_arbiter_if #(.DWIDTH(32)) bus ();
  alu_arbiter #(.DWIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data};
  assign rdy = {bus.req0_ready, bus.req1_ready};
  task automatic idle();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_sel = 0; bus.req1_sel = 0;
    bus.req0_a = 0; bus.req1_a = 0; bus.req0_b = 0; bus.req1_b = 0;
`ifdef ALU_ARB_LOCK_EN
    bus.req0_lock = 0; bus.req1_lock = 0;
`endif
    bus.rsp_ready = 1;
  endtask
  task automatic req(input int i, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      bus.req0_valid = 1; bus.req0_sel = sel; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1; bus.req1_sel = sel; bus.req1_a = a; bus.req1_b = b;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    idle();
    req(0, ALU_ADD, 1, 1);
    req(1, ALU_ADD, 2, 2);
    @(negedge clk); #1;
    vectors++;
    if (rsp !== 35'd0) begin errors++; $display("FAIL reset_rsp got %h exp %h", rsp, 35'd0); end
    vectors++;
    if (rdy !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp %b", rdy, 2'b00); end
  endtask
  task automatic test_round_robin();
    do_reset();
    req(0, ALU_ADD, 5, 7);
    req(1, ALU_SUB, 9, 4);
    #1; vectors++;
    if (rdy !== 2'b10) begin errors++; $display("FAIL rr_ready0 got %b exp %b", rdy, 2'b10); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd12}) begin errors++; $display("FAIL rr_add got %h exp %h", rsp, {3'b100, 32'd12}); end
    req(0, ALU_ADD, 1, 1);
    #1; vectors++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL rr_ready1 got %b exp %b", rdy, 2'b01); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b110, 32'd5}) begin errors++; $display("FAIL rr_sub got %h exp %h", rsp, {3'b110, 32'd5}); end
    bus.req1_valid = 0;
    #1; vectors++;
    if (rdy !== 2'b10) begin errors++; $display("FAIL rr_ready2 got %b exp %b", rdy, 2'b10); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd2}) begin errors++; $display("FAIL rr_add2 got %h exp %h", rsp, {3'b100, 32'd2}); end
    idle();
    @(negedge clk);
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp %b", bus.rsp_valid, 1'b0); end
  endtask
  task automatic test_shift();
    do_reset();
    req(1, ALU_SLL, 32'd1, 32'h21);
    #1; vectors++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL sll_ready got %b exp %b", rdy, 2'b01); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b110, 32'd2}) begin errors++; $display("FAIL sll got %h exp %h", rsp, {3'b110, 32'd2}); end
    req(1, ALU_SRL, 32'h80, 32'h23);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b110, 32'h10}) begin errors++; $display("FAIL srl got %h exp %h", rsp, {3'b110, 32'h10}); end
    idle();
  endtask
  task automatic test_stall();
    do_reset();
    bus.rsp_ready = 0;
    req(0, ALU_OR, 32'hF0, 32'h0F);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'hFF}) begin errors++; $display("FAIL stall_load got %h exp %h", rsp, {3'b100, 32'hFF}); end
    req(0, ALU_ADD, 1, 2);
    req(1, ALU_XOR, 6, 3);
    for (int i = 0; i < 3; i++) begin
      #1; vectors++;
      if (rdy !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got %b exp %b", i, rdy, 2'b00); end
      vectors++;
      if (rsp !== {3'b100, 32'hFF}) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, rsp, {3'b100, 32'hFF}); end
      @(negedge clk);
    end
    bus.rsp_ready = 1;
    #1; vectors++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL stall_release got %b exp %b", rdy, 2'b01); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b110, 32'd5}) begin errors++; $display("FAIL stall_xor got %h exp %h", rsp, {3'b110, 32'd5}); end
    bus.req1_valid = 0;
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd3}) begin errors++; $display("FAIL stall_add got %h exp %h", rsp, {3'b100, 32'd3}); end
    idle();
  endtask
  task automatic test_illegal();
    do_reset();
    req(0, 4'd12, 3, 4);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b101, 32'd0}) begin errors++; $display("FAIL illegal12 got %h exp %h", rsp, {3'b101, 32'd0}); end
    req(0, ALU_SLT, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd1}) begin errors++; $display("FAIL slt got %h exp %h", rsp, {3'b100, 32'd1}); end
    req(0, ALU_SLTU, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd0}) begin errors++; $display("FAIL sltu got %h exp %h", rsp, {3'b100, 32'd0}); end
    req(0, 4'd9, 7, 7);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b101, 32'd0}) begin errors++; $display("FAIL illegal9 got %h exp %h", rsp, {3'b101, 32'd0}); end
    idle();
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.rsp_ready = 0;
    req(0, ALU_ADD, 1, 1);
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd2}) begin errors++; $display("FAIL mid_load got %h exp %h", rsp, {3'b100, 32'd2}); end
    req(1, ALU_ADD, 2, 2);
    rst_n = 0;
    #1; vectors++;
    if (rsp !== 35'd0) begin errors++; $display("FAIL mid_clear got %h exp %h", rsp, 35'd0); end
    vectors++;
    if (rdy !== 2'b00) begin errors++; $display("FAIL mid_ready got %b exp %b", rdy, 2'b00); end
    @(negedge clk);
    rst_n = 1;
    #1; vectors++;
    if (rdy !== 2'b10) begin errors++; $display("FAIL mid_first_grant got %b exp %b", rdy, 2'b10); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b100, 32'd2}) begin errors++; $display("FAIL mid_after got %h exp %h", rsp, {3'b100, 32'd2}); end
    idle();
  endtask
`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req(1, ALU_ADD, 100, 0);
    req(0, ALU_ADD, 1, 0);
    bus.req0_lock = 1;
    for (int i = 1; i <= 3; i++) begin
      bus.req0_a = i;
      bus.req0_lock = (i < 3);
      #1; vectors++;
      if (rdy !== 2'b10) begin errors++; $display("FAIL lock_ready[%0d] got %b exp %b", i, rdy, 2'b10); end
      @(negedge clk);
      vectors++;
      if (rsp !== {3'b100, 32'(i)}) begin errors++; $display("FAIL lock_rsp[%0d] got %h exp %h", i, rsp, {3'b100, 32'(i)}); end
    end
    #1; vectors++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL lock_release got %b exp %b", rdy, 2'b01); end
    @(negedge clk);
    vectors++;
    if (rsp !== {3'b110, 32'd100}) begin errors++; $display("FAIL lock_req1 got %h exp %h", rsp, {3'b110, 32'd100}); end
    idle();
  endtask
`endif
  initial begin
    test_reset();
    test_round_robin();
    test_shift();
    test_stall();
    test_illegal();
    test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  operation offered by requester 0/1.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_sel/req1_sel  input  4  ALU operation code.
REQ-007 SHALL have ports req0_a/req1_a, req0_b/req1_b  input  DWIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port rsp_id  output  1  requester owning the result.
REQ-011 SHALL have port rsp_data  output  DWIDTH  result.
REQ-012 SHALL have port rsp_err  output  1  result came from an illegal op code.

Function
REQ-013 SHALL share one ALU instance between requesters; at most one operation accepted per cycle.
REQ-014 SHALL accept when slot free: free = !rsp_valid || rsp_ready; req_ready for the granted requester = its valid && free; other ready = 0.
REQ-015 SHALL register the result: accepted op appears on rsp_* the next cycle (latency 1), throughput 1/cycle while rsp_ready=1.
REQ-016 SHALL hold rsp_valid/rsp_id/rsp_data/rsp_err stable while rsp_valid && !rsp_ready.
REQ-017 SHALL arbitrate round-robin with FSM states PRI0, PRI1 (preferred requester); both valid -> grant preferred; one valid -> grant it.
REQ-018 SHALL transition PRI0->PRI1 on a requester-0 accept and PRI1->PRI0 on a requester-1 accept; no accept -> hold state.
REQ-019 SHALL not change state or grant while free=0 (stall); requesters observe ready=0.
REQ-020 SHALL mask portb to {0, b[4:0]} for op codes 4 (SLL) and 7 (SRL); other ops pass b unchanged.
REQ-021 SHALL treat op codes 9-15 as illegal: accept normally, rsp_data = 0, rsp_err = 1.
REQ-022 SHALL, with rsp_valid && rsp_ready && new accept in the same cycle, load the new result (no bubble).

Reset
REQ-023 SHALL on rst_n=0 asynchronously set rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, state=PRI0 (and lock cleared).
REQ-024 SHALL drop any in-flight result on reset mid-operation; req_ready = 0 while rst_n=0.

Configuration
REQ-025 SHALL, with ALU_ARB_LOCK_EN defined, add inputs req0_lock/req1_lock (1 bit) and states LOCK0/LOCK1: an accept with lock=1 enters LOCK of that requester, which is granted exclusively until it is accepted with lock=0 (then -> PRI of the other requester).
REQ-026 SHALL, without ALU_ARB_LOCK_EN, omit lock ports and LOCK states; pure round-robin per REQ-017/018.

Structure
REQ-027 SHALL take ALUSEL constants (ADD=0, AND=1, XOR=2, SUB=3, SLL=4, SLT=5, SLTU=6, SRL=7, OR=8), LAST_LEGAL_OP=8 and FSM state encoding from shared package alu_pkg.
REQ-028 SHALL instantiate existing sub-module alu (DWIDTH passed through) as the only datapath; arbitration, masking and result register live in alu_arbiter.

Verification
REQ-029 SHALL cover: after reset both valid, req0 ADD 5+7, req1 SUB 9-4, rsp_ready=1 -> cycle+1 rsp_id=0 data=12, cycle+2 rsp_id=1 data=5.
REQ-030 SHALL cover: req1 alone SLL a=1 b=0x21 -> rsp_data=2 (shift 1), rsp_err=0.
REQ-031 SHALL cover: rsp_ready=0 for 3 cycles with result 0xFF held -> rsp_data stays 0xFF, both req_ready=0, state unchanged; rsp_ready=1 -> next op accepted same cycle.
REQ-032 SHALL cover: req0 op code 12 -> rsp_data=0, rsp_err=1; following SLT a=-1 b=0 -> data=1, err=0.
REQ-033 SHALL cover: rst_n low mid-stream with rsp_valid=1 -> rsp_valid=0 immediately, first grant after release to req0.
REQ-034 SHALL cover (ALU_ARB_LOCK_EN): req0 lock=1 for 3 ops with req1 valid throughout -> three req0 results, then req1 granted.
